lsu_bram_ctrl: RTL and testbench

LSU_BRAM_CTRL -- requirements
Module: lsu_bram_ctrl

---
 rtl/lsu_bram_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lsu_bram_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bram_ctrl.sv
// Load/store unit front-end for a single-port 32-bit block RAM.
// Accepts one CPU request at a time, performs the RAM access and returns an aligned, extended response.
module lsu_bram_ctrl #(
    parameter int RAM_ADDR_WIDTH = 13,
    parameter int RAM_BUS_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [31:0]               resp_rdata,
    output logic                      resp_err,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [3:0]                ram_we,
    output logic [RAM_BUS_WIDTH-1:0]  ram_wdata,
    input  logic [RAM_BUS_WIDTH-1:0]  ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                    state_r;
    logic                      req_ready_r;
    logic                      resp_valid_r;
    logic                      resp_err_r;
    logic [31:0]               resp_rdata_r;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_r;
    logic [3:0]                ram_we_r;
    logic [RAM_BUS_WIDTH-1:0]  ram_wdata_r;
    logic                      write_r;
    logic [1:0]                size_r;
    logic [1:0]                lane_r;
    logic                      uns_r;

    logic                      acc_err_s;
    logic [3:0]                acc_we_s;
    logic [RAM_BUS_WIDTH-1:0]  acc_wdata_s;

    function automatic logic req_illegal(input logic [1:0] size, input logic [31:0] addr);
        logic res;
        case (size)
            2'b00:   res = 1'b0;
            2'b01:   res = addr[0];
            2'b10:   res = (addr[1:0] != 2'b00);
            default: res = 1'b1;
        endcase
        return res | ((addr >> (RAM_ADDR_WIDTH + 2)) != 32'd0);
    endfunction

    function automatic logic [3:0] store_we(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] res;
        case (size)
            2'b00:   res = 4'b0001 << lane;
            2'b01:   res = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   res = 4'b1111;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] res;
        case (size)
            2'b00:   res = {4{wdata[7:0]}};
            2'b01:   res = {2{wdata[15:0]}};
            default: res = wdata;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [31:0] byte_s;
        logic [31:0] half_s;
        logic [31:0] res;
        byte_s = word >> {lane, 3'b000};
        half_s = word >> {lane[1], 4'b0000};
        case (size)
            2'b00:   res = uns ? {24'd0, byte_s[7:0]} : {{24{byte_s[7]}}, byte_s[7:0]};
            2'b01:   res = uns ? {16'd0, half_s[15:0]} : {{16{half_s[15]}}, half_s[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Decode the incoming request: legality, byte enables and lane-replicated data
    always_comb begin
        acc_err_s   = req_illegal(req_size, req_addr);
        acc_we_s    = store_we(req_size, req_addr[1:0]);
        acc_wdata_s = store_data(req_size, req_wdata);
    end

    // Request/response FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
            ram_addr_r   <= '0;
            ram_we_r     <= 4'd0;
            ram_wdata_r  <= '0;
            write_r      <= 1'b0;
            size_r       <= 2'd0;
            lane_r       <= 2'd0;
            uns_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready_r <= 1'b0;
                        ram_addr_r  <= req_addr[RAM_ADDR_WIDTH+1:2];
                        write_r     <= req_write;
                        size_r      <= req_size;
                        lane_r      <= req_addr[1:0];
                        uns_r       <= req_unsigned;
                        if (acc_err_s) begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'd0;
                        end else begin
                            state_r <= ST_ACCESS;
                            if (req_write) begin
                                ram_we_r    <= acc_we_s;
                                ram_wdata_r <= acc_wdata_s;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    ram_we_r <= 4'd0;
                    if (write_r) begin
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= 32'd0;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // RAM read data for the address driven in ACCESS is valid now
                    state_r      <= ST_RESP;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= load_extend(ram_rdata, size_r, lane_r, uns_r);
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_r      <= ST_IDLE;
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    ram_we_r     <= 4'd0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;
    assign ram_addr   = ram_addr_r;
    assign ram_we     = ram_we_r;
    assign ram_wdata  = ram_wdata_r;

endmodule

// File: tb/tb_lsu_bram_ctrl.sv
// Bench for lsu_bram_ctrl: directed vectors plus random traffic against a byte-array memory model.
module tb_lsu_bram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [12:0] ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mem [0:8191];
    logic        mem_ready = 1'b0;
    logic [7:0]  ref_bytes [0:32767];

    int          we_total = 0;
    logic [3:0]  seen_we;
    logic [31:0] seen_wdata;
    logic [12:0] seen_addr;

    lsu_bram_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Block RAM with registered read and byte write enables
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 32'd0;
            mem_ready <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b] === 1'b1) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= mem[ram_addr];
    end

    // Record every cycle in which the RAM is being written
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ram_we != 4'd0) begin
            we_total   <= we_total + 1;
            seen_we    <= ram_we;
            seen_wdata <= ram_wdata;
            seen_addr  <= ram_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                           input logic [31:0] wd, input int hold, output logic [31:0] got);
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] val;
        int          exp_lat;
        int          nb;
        int          lane;
        int          we0;
        int          n;
        nb   = 1 << sz;
        lane = int'(a[1:0]);
        exp_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
                  (a >= 32'h0000_8000);
        exp_we = 4'd0;
        exp_wdata = 32'd0;
        val = 32'd0;
        if (!exp_err) begin
            for (int i = 0; i < nb; i++) begin
                exp_we[lane + i] = 1'b1;
                val = val | (32'(ref_bytes[int'(a[14:0]) + i]) << (8 * i));
            end
            for (int l = 0; l < 4; l++) exp_wdata[8*l +: 8] = wd[8*(l % nb) +: 8];
            if (!u && nb < 4 && val[8*nb-1]) val = val | ~((32'd1 << (8 * nb)) - 32'd1);
        end
        exp_lat   = exp_err ? 1 : (w ? 2 : 3);
        exp_rdata = (exp_err || w) ? 32'd0 : val;

        @(negedge clk);
        check("ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        we0 = we_total;
        @(posedge clk);
        @(negedge clk);
        req_valid = (hold > 0);
        req_write = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
        req_unsigned = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
        n = 1;
        while (resp_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, exp_lat);
        check("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
        check("resp_rdata", resp_rdata, exp_rdata);
        check("ready_busy", {31'd0, req_ready}, 32'd0);
        if (!exp_err) check("ram_addr", {19'd0, ram_addr}, {19'd0, a[14:2]});
        got = resp_rdata;
        if (w && !exp_err) begin
            check("we_cycles", we_total - we0, 1);
            check("ram_we", {28'd0, seen_we}, {28'd0, exp_we});
            check("ram_wdata", seen_wdata, exp_wdata);
            check("we_addr", {19'd0, seen_addr}, {19'd0, a[14:2]});
            for (int i = 0; i < nb; i++) ref_bytes[int'(a[14:0]) + i] = wd[8*i +: 8];
        end else begin
            check("no_write", we_total - we0, 0);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, got);
            check("hold_err", {31'd0, resp_err}, {31'd0, exp_err});
            check("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("resp_drop", {31'd0, resp_valid}, 32'd0);
        check("ready_after", {31'd0, req_ready}, 32'd1);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 32768; i++) ref_bytes[i] = 8'd0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_we", {28'd0, ram_we}, 32'd0);
        check("rst_addr", {19'd0, ram_addr}, 32'd0);
        check("rst_wdata", ram_wdata, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        run_req(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 0, got);
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 0, got);
        check("vec_word_load", got, 32'hDEAD_BEEF);
        run_req(1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_0055, 0, got);
        run_req(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'd0, 0, got);
        check("vec_byte_load", got, 32'h0000_0055);
        check("vec_ram_word", mem[13'h040], 32'h55AD_BEEF);

        run_req(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h80FF_1234, 0, got);
        run_req(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'd0, 0, got);
        check("vec_half_s", got, 32'hFFFF_80FF);
        run_req(1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'd0, 0, got);
        check("vec_half_u", got, 32'h0000_80FF);
        run_req(1'b0, 2'd0, 1'b0, 32'h0000_0100, 32'd0, 0, got);
        check("vec_byte_s", got, 32'h0000_0034);

        run_req(1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'hAAAA_AAAA, 0, got);
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'd0, 0, got);
        run_req(1'b1, 2'd3, 1'b0, 32'h0000_0100, 32'hBBBB_BBBB, 0, got);
        run_req(1'b1, 2'd2, 1'b0, 32'h0000_8000, 32'hCCCC_CCCC, 0, got);
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'd0, 0, got);
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 5, got);
        check("vec_mem_kept", got, 32'h80FF_1234);

        // Reset in the middle of a word store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0000_0200; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("mid_we", {28'd0, ram_we}, 32'hF);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", {28'd0, ram_we}, 32'd0);
        check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 0, got);
        check("post_rst_load", got, 32'h80FF_1234);

        for (int k = 0; k < 40; k++) begin
            w  = $urandom_range(0, 1);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 9) == 0) ? $urandom : (32'h0000_0100 + 32'($urandom_range(0, 63)));
            run_req(w, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
